// File: rtl/usb4_enc_pkg.sv
// USB4 lane encoder shared definitions: generation codes, sync headers,
// per-generation byte counts and header widths.
package usb4_enc_pkg;

    localparam logic [1:0] GEN4   = 2'd0;
    localparam logic [1:0] GEN3   = 2'd1;
    localparam logic [1:0] GEN2   = 2'd2;
    localparam logic [1:0] GENRSV = 2'd3;

    localparam logic [1:0] HDR2_OS = 2'b01;
    localparam logic [1:0] HDR2_TD = 2'b10;
    localparam logic [3:0] HDR4_OS = 4'b0101;
    localparam logic [3:0] HDR4_TD = 4'b1010;

    localparam int GEN2_BYTES = 8;
    localparam int GEN3_BYTES = 16;
    localparam int MAX_BYTES  = 16;

    // Reserved generation yields 0 bytes so no byte ever counts as last.
    function automatic logic [4:0] sym_bytes(input logic [1:0] gen);
        case (gen)
            GEN4:    return 5'd1;
            GEN3:    return 5'(GEN3_BYTES);
            GEN2:    return 5'(GEN2_BYTES);
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] hdr_w(input logic [1:0] gen);
        case (gen)
            GEN3:    return 3'd4;
            GEN2:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] sync_hdr(input logic [1:0] gen,
                                            input logic       kind);
        case (gen)
            GEN3:    return kind ? HDR4_TD : HDR4_OS;
            GEN2:    return {2'b00, (kind ? HDR2_TD : HDR2_OS)};
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/usb4_sym_packer.sv
// Per-lane symbol assembler: stores accepted bytes and forms {bytes, header}.
// Ports: wr_en_i/wr_idx_i/byte_i write a byte; mode_i/kind_i pick the
// header; sym_o is the zero-extended lane symbol including byte_i in its slot.
module usb4_sym_packer
    import usb4_enc_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int SYM_W  = 132
) (
    input  logic              enc_clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_idx_i,
    input  logic [LANE_W-1:0] byte_i,
    input  logic [1:0]        mode_i,
    input  logic              kind_i,
    output logic [SYM_W-1:0]  sym_o
);

    logic [LANE_W-1:0]           mem_q [MAX_BYTES];
    logic [MAX_BYTES*LANE_W-1:0] payload;
    logic [4:0]                  nb;

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= byte_i;
        end
    end

    // Bytes beyond the active symbol length are masked so stale data
    // from a longer mode never leaks into the upper bits.
    always_comb begin
        payload = '0;
        nb      = sym_bytes(mode_i);
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (5'(i) < nb) begin
                payload[i*LANE_W +: LANE_W] =
                    (4'(i) == wr_idx_i) ? byte_i : mem_q[i];
            end
        end
        sym_o = (SYM_W'(payload) << hdr_w(mode_i))
              | SYM_W'(sync_hdr(mode_i, kind_i));
    end

endmodule

// File: rtl/usb4_lane_encoder_p.sv
// USB4 N-lane transmit encoder (Gen2 64b/66b, Gen3 128b/132b, Gen4 pass).
// Ports: valid/ready byte input, valid/ready symbol output, new_sym, drop_pulse.
module usb4_lane_encoder_p
    import usb4_enc_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 8,
    parameter int SYM_W     = 132
) (
    input  logic                          enc_clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    gen_speed,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES*LANE_W-1:0]   in_data,
    input  logic                          in_transport,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*SYM_W-1:0]    out_data,
    output logic                          new_sym,
    output logic                          drop_pulse
);

    logic [3:0]                 cnt_q, cnt_d;
    logic                       kind_q, kind_d;
    logic [1:0]                 mode_q;
    logic                       ov_q, ov_d;
    logic [NUM_LANES*SYM_W-1:0] od_q, od_d;
    logic                       ns_q, ns_d;
    logic                       dp_q, dp_d;
    logic [NUM_LANES*SYM_W-1:0] sym_w;
    logic [4:0]                 nb;
    logic                       last, mode_chg, acc, load, kind_cur;

    assign nb       = sym_bytes(gen_speed);
    assign last     = ({1'b0, cnt_q} == (nb - 5'd1));
    assign mode_chg = (gen_speed != mode_q) && (cnt_q != 4'd0);
    // Last byte only goes in when the output slot frees the same cycle.
    assign in_ready = enable && (gen_speed != GENRSV) && !mode_chg
                    && (!last || !ov_q || out_ready);
    assign acc      = in_valid && in_ready;
    assign load     = acc && last;
    assign kind_cur = (cnt_q == 4'd0) ? in_transport : kind_q;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        usb4_sym_packer #(
            .LANE_W (LANE_W),
            .SYM_W  (SYM_W)
        ) u_pack (
            .enc_clk  (enc_clk),
            .rst      (rst),
            .wr_en_i  (acc),
            .wr_idx_i (cnt_q),
            .byte_i   (in_data[k*LANE_W +: LANE_W]),
            .mode_i   (gen_speed),
            .kind_i   (kind_cur),
            .sym_o    (sym_w[k*SYM_W +: SYM_W])
        );
    end

    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        ov_d   = ov_q;
        od_d   = od_q;
        ns_d   = 1'b0;
        dp_d   = 1'b0;
        unique case (1'b1)
            !enable: begin
                cnt_d = 4'd0;
                ov_d  = 1'b0;
                od_d  = '0;
                dp_d  = (cnt_q != 4'd0);
            end
            default: begin
                if (mode_chg) begin
                    cnt_d = 4'd0;
                    dp_d  = 1'b1;
                end
                if (acc) begin
                    cnt_d = last ? 4'd0 : cnt_q + 4'd1;
                    if (cnt_q == 4'd0) begin
                        kind_d = in_transport;
                    end
                end
                if (load) begin
                    ov_d = 1'b1;
                    od_d = sym_w;
                    ns_d = 1'b1;
                end else if (out_ready) begin
                    ov_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge enc_clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 4'd0;
            kind_q <= 1'b0;
            mode_q <= GEN4;
            ov_q   <= 1'b0;
            od_q   <= '0;
            ns_q   <= 1'b0;
            dp_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            mode_q <= gen_speed;
            ov_q   <= ov_d;
            od_q   <= od_d;
            ns_q   <= ns_d;
            dp_q   <= dp_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign new_sym    = ns_q;
    assign drop_pulse = dp_q;

endmodule

// File: tb/tb_usb4_lane_encoder_p.sv
// Testbench for usb4_lane_encoder_p: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_usb4_lane_encoder_p;

    localparam int NL = 2;
    localparam int SW = 132;
    localparam int DW = NL * 8;
    localparam int OW = NL * SW;

    logic          enc_clk;
    logic          rst;
    logic          enable;
    logic [1:0]    gen_speed;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_transport;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          new_sym;
    logic          drop_pulse;

    usb4_lane_encoder_p #(
        .NUM_LANES (NL),
        .LANE_W    (8),
        .SYM_W     (SW)
    ) dut (
        .enc_clk      (enc_clk),
        .rst          (rst),
        .enable       (enable),
        .gen_speed    (gen_speed),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_transport (in_transport),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .new_sym      (new_sym),
        .drop_pulse   (drop_pulse)
    );

    initial enc_clk = 1'b0;
    always #5 enc_clk = ~enc_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [OW-1:0] obs,
                       input logic [OW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // Reference model: bytes collected so far for the current symbol.
    logic [DW-1:0] mq[$];
    bit            m_kind;
    bit [1:0]      m_mode;
    bit            m_ov, m_ns, m_dp;
    logic [OW-1:0] m_od;

    function automatic int nbytes(input bit [1:0] g);
        case (g)
            2'd0:    return 1;
            2'd1:    return 16;
            2'd2:    return 8;
            default: return 0;
        endcase
    endfunction

    function automatic logic [OW-1:0] build(input int n, input bit [1:0] g,
                                            input bit kind);
        logic [OW-1:0] r;
        logic [SW-1:0] s;
        int            h, hv;
        h  = (g == 2'd1) ? 4 : (g == 2'd2) ? 2 : 0;
        hv = (g == 2'd1) ? (kind ? 10 : 5) : (g == 2'd2) ? (kind ? 2 : 1) : 0;
        r  = '0;
        for (int k = 0; k < NL; k++) begin
            s = SW'(hv);
            for (int i = 0; i < n; i++) begin
                s = s | (SW'(mq[i][k*8 +: 8]) << (h + 8 * i));
            end
            r[k*SW +: SW] = s;
        end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_kind = 0; m_mode = 0; m_ov = 0; m_ns = 0; m_dp = 0;
        m_od = '0;
    endtask

    task automatic model_edge(input bit en, input bit [1:0] g, input bit iv,
                              input logic [DW-1:0] d, input bit it,
                              input bit ordy, output bit rdy);
        int n, c;
        bit chg, acc;
        n = nbytes(g);
        c = mq.size();
        m_ns = 0; m_dp = 0; rdy = 0;
        if (!en) begin
            m_dp = (c != 0);
            mq.delete();
            m_ov = 0;
            m_od = '0;
        end else begin
            chg = (g != m_mode) && (c != 0);
            rdy = (g != 2'd3) && !chg && (c != n - 1 || !m_ov || ordy);
            acc = iv && rdy;
            if (chg) begin
                m_dp = 1;
                mq.delete();
            end
            if (ordy) m_ov = 0;
            if (acc) begin
                if (c == 0) m_kind = it;
                mq.push_back(d);
                if (mq.size() == n) begin
                    m_od = build(n, g, m_kind);
                    m_ov = 1;
                    m_ns = 1;
                    mq.delete();
                end
            end
        end
        m_mode = g;
    endtask

    // Called just after a falling edge; returns after the next falling edge.
    task automatic step(input bit en, input bit [1:0] g, input bit iv,
                        input logic [DW-1:0] d, input bit it, input bit ordy);
        bit r;
        enable = en; gen_speed = g; in_valid = iv;
        in_data = d; in_transport = it; out_ready = ordy;
        model_edge(en, g, iv, d, it, ordy, r);
        #1 chk("in_ready", OW'(in_ready), OW'(r));
        @(negedge enc_clk);
        chk("out_valid", OW'(out_valid), OW'(m_ov));
        chk("new_sym", OW'(new_sym), OW'(m_ns));
        chk("drop_pulse", OW'(drop_pulse), OW'(m_dp));
        chk("out_data", out_data, m_od);
    endtask

    function automatic logic [DW-1:0] lanes(input logic [7:0] b0,
                                            input logic [7:0] b1);
        return {b1, b0};
    endfunction

    bit [1:0] rg;

    initial begin
        rst = 1'b0; enable = 1'b0; gen_speed = 2'd0; in_valid = 1'b0;
        in_data = '0; in_transport = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge enc_clk);
        @(negedge enc_clk);
        chk("rst_ov", OW'(out_valid), '0);
        chk("rst_od", out_data, '0);
        chk("rst_ns", OW'(new_sym), '0);
        chk("rst_dp", OW'(drop_pulse), '0);
        rst = 1'b1;
        @(negedge enc_clk);

        // Gen3 transport symbol, two lanes.
        for (int i = 0; i < 16; i++) begin
            step(1, 2'd1, 1, lanes(8'(i), 8'(8'hF0 + i)), (i == 0), 1);
        end
        chk("t1_ns", OW'(new_sym), OW'(1));
        chk("t1_hdr", OW'(out_data[3:0]), OW'(4'b1010));
        chk("t1_b0", OW'(out_data[11:4]), OW'(8'h00));
        chk("t1_b15", OW'(out_data[131:124]), OW'(8'h0F));
        chk("t1_l1b15", OW'(out_data[SW+124 +: 8]), OW'(8'hFF));

        // Gen2 ordered set.
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd2, 1, lanes(8'(8'hA0 + i), 8'(i)), (i != 0), 1);
        end
        chk("t2_hdr", OW'(out_data[1:0]), OW'(2'b01));
        chk("t2_pay", OW'(out_data[65:2]), OW'(64'hA7A6A5A4A3A2A1A0));
        chk("t2_top", OW'(out_data[131:66]), '0);

        // Gen2 backpressure.
        step(1, 2'd2, 0, '0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step(1, 2'd2, 1, lanes(8'(8'h50 + i), 8'(8'h60 + i)), 1, 0);
        end
        step(1, 2'd2, 1, lanes(8'h5F, 8'h6F), 1, 0);
        chk("t3_stall", OW'(in_ready), '0);
        step(1, 2'd2, 1, lanes(8'h5F, 8'h6F), 1, 1);
        chk("t3_newsym", OW'(new_sym), OW'(1));
        chk("t3_b7", OW'(out_data[65:58]), OW'(8'h5F));

        // Mode change mid-symbol.
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd1, 1, lanes(8'(8'hC0 + i), 8'hCC), 1, 1);
        end
        step(1, 2'd2, 1, lanes(8'hEE, 8'hEE), 1, 1);
        chk("t4_drop", OW'(drop_pulse), OW'(1));
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd2, 1, lanes(8'(8'h30 + i), 8'h44), 1, 1);
        end
        chk("t4_pay", OW'(out_data[65:2]), OW'(64'h3736353433323130));

        // Gen4 pass-through.
        step(1, 2'd0, 1, lanes(8'h11, 8'h91), 0, 1);
        chk("t5_a", OW'(out_data[7:0]), OW'(8'h11));
        step(1, 2'd0, 1, lanes(8'h22, 8'h92), 1, 1);
        chk("t5_b", OW'(out_data[7:0]), OW'(8'h22));
        chk("t5_bns", OW'(new_sym), OW'(1));
        step(1, 2'd0, 1, lanes(8'h33, 8'h93), 0, 1);
        chk("t5_c", OW'(out_data[7:0]), OW'(8'h33));
        chk("t5_cns", OW'(new_sym), OW'(1));

        // Flush at cnt 9, then asynchronous reset mid-symbol.
        for (int i = 0; i < 9; i++) begin
            step(1, 2'd1, 1, lanes(8'(i), 8'(i)), 1, 1);
        end
        step(0, 2'd1, 1, lanes(8'h99, 8'h99), 1, 1);
        chk("t6_drop", OW'(drop_pulse), OW'(1));
        chk("t6_ov", OW'(out_valid), '0);
        for (int i = 0; i < 16; i++) begin
            step(1, 2'd1, 1, lanes(8'(8'h80 + i), 8'(i)), 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 2'd2, 1, lanes(8'(8'h70 + i), 8'h07), 0, 1);
        end
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_ov", OW'(out_valid), '0);
        chk("t6_rst_od", out_data, '0);
        chk("t6_rst_dp", OW'(drop_pulse), '0);
        model_reset();
        @(negedge enc_clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, 2'd2, 1, lanes(8'(8'hB0 + i), 8'h0B), 1, 1);
        end
        chk("t6_pay", OW'(out_data[65:2]), OW'(64'hB7B6B5B4B3B2B1B0));

        // Random traffic.
        rg = 2'd1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 120) == 0) rg = 2'($urandom_range(0, 3));
            step($urandom_range(0, 250) != 0, rg,
                 $urandom_range(0, 9) < 8, DW'($urandom),
                 1'($urandom), $urandom_range(0, 9) < 7);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
